// File: rtl/pyramid_pkg.sv
// -----------------------------------------------------------------------------
// pyramid_pkg
//   Constants and types shared by the pyramid vertex sequencer and its
//   interface: the coordinate width, the default screen offsets and the
//   sequencer state encoding.
// -----------------------------------------------------------------------------
package pyramid_pkg;

  localparam int CW          = 10;   // coordinate width (signed 2D/3D, screen)
  localparam int SHIFT_X_DEF = 320;  // default screen X offset
  localparam int SHIFT_Y_DEF = 340;  // default screen Y offset

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pyramid_seq_if.sv
// -----------------------------------------------------------------------------
// pyramid_seq_if
//   Bundles the frame control, transform-unit handshake and vertex-store write
//   signals of pyramid_seq.
//   Modports:
//     slave  - the sequencer: takes start_t, xf_ack and transform results,
//              drives busy/done/overrun, xf_req/xf_idx, wr_* and wb_*.
//     master - the surrounding logic: the mirror image of slave.
//   Parameter NUM_V must match the NUM_V of the connected pyramid_seq.
// -----------------------------------------------------------------------------
interface pyramid_seq_if #(
  parameter int NUM_V = 5
);
  import pyramid_pkg::*;

  localparam int IW = $clog2(NUM_V);

  // frame control
  logic                 start_t;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  // transform unit handshake
  logic                 xf_req;
  logic                 xf_ack;
  logic [IW-1:0]        xf_idx;
  logic signed [CW-1:0] xf_x2d;
  logic signed [CW-1:0] xf_y2d;
  logic signed [CW-1:0] xf_x3d;
  logic signed [CW-1:0] xf_y3d;
  // 2D vertex store write
  logic                 wr_en;
  logic [IW-1:0]        wr_idx;
  logic [CW-1:0]        wr_x;
  logic [CW-1:0]        wr_y;
  // 3D vertex store write-back (same address as wr_idx)
  logic                 wb_en;
  logic [CW-1:0]        wb_x;
  logic [CW-1:0]        wb_y;

  modport slave (
    input  start_t, xf_ack, xf_x2d, xf_y2d, xf_x3d, xf_y3d,
    output busy, done, overrun, xf_req, xf_idx,
           wr_en, wr_idx, wr_x, wr_y, wb_en, wb_x, wb_y
  );

  modport master (
    output start_t, xf_ack, xf_x2d, xf_y2d, xf_x3d, xf_y3d,
    input  busy, done, overrun, xf_req, xf_idx,
           wr_en, wr_idx, wr_x, wr_y, wb_en, wb_x, wb_y
  );

endinterface

// File: rtl/pyramid_seq.sv
// -----------------------------------------------------------------------------
// pyramid_seq
//   Walks the NUM_V vertices of a pyramid once per start_t pulse. For each
//   vertex it requests a rotate/isometric transform from an external shared
//   unit, then writes the projected point, shifted into screen space, to the
//   2D vertex store. A frame takes 2*NUM_V+1 cycles when every ack is
//   immediate.
//
//   Ports:
//     clk    - single clock, rising edge
//     rst_n  - asynchronous active-low reset; clears FSM, index and outputs
//     bus    - pyramid_seq_if.slave (start/busy/done/overrun, xf_* handshake,
//              wr_* 2D store write, wb_* 3D store write-back)
//
//   Build option:
//     SEQ_WRITEBACK_EN - when defined, the WRITE cycle also writes the rotated
//                        3D coordinates back (wb_en/wb_x/wb_y), so rotation
//                        accumulates frame over frame. Otherwise wb_* are 0.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start_t
//   REQ   | xf_req high for vertex idx, waiting for xf_ack
//   WRITE | one-cycle store write of vertex idx
//   DONE  | one-cycle done pulse; start_t here begins a new frame directly
// -----------------------------------------------------------------------------
module pyramid_seq
  import pyramid_pkg::*;
#(
  parameter int NUM_V   = 5,
  parameter int SHIFT_X = SHIFT_X_DEF,
  parameter int SHIFT_Y = SHIFT_Y_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  pyramid_seq_if.slave  bus
);

  localparam int            IW       = $clog2(NUM_V);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_V - 1);
  // Offsets reduced to the coordinate width: the add wraps modulo 2^CW.
  localparam logic [CW-1:0] SX       = CW'(SHIFT_X);
  localparam logic [CW-1:0] SY       = CW'(SHIFT_Y);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          xf_req_q, xf_req_d;
  logic [IW-1:0] xf_idx_q, xf_idx_d;
  logic          wr_en_q, wr_en_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [CW-1:0] wr_x_q, wr_x_d;
  logic [CW-1:0] wr_y_q, wr_y_d;

`ifdef SEQ_WRITEBACK_EN
  logic          wb_en_q, wb_en_d;
  logic [CW-1:0] wb_x_q, wb_x_d;
  logic [CW-1:0] wb_y_q, wb_y_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_t) begin
          state_d = REQ;
          idx_d   = '0;
        end
      end
      REQ: begin
        if (bus.xf_ack) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = REQ;
          idx_d   = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.start_t) begin
          state_d = REQ;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off
    // flops; xf_req therefore has no combinational path from xf_ack.
    busy_d    = (state_d == REQ) || (state_d == WRITE);
    done_d    = (state_d == DONE);
    xf_req_d  = (state_d == REQ);
    xf_idx_d  = (state_d == REQ) ? idx_d : '0;
    overrun_d = overrun_q | (bus.start_t & busy_q);

    // Entering WRITE only happens on the ack cycle, so this registers the
    // transform result exactly once per vertex and holds it for the write.
    wr_en_d   = (state_d == WRITE);
    wr_idx_d  = (state_d == WRITE) ? idx_q : '0;
    wr_x_d    = (state_d == WRITE) ? (bus.xf_x2d + SX) : '0;
    wr_y_d    = (state_d == WRITE) ? (bus.xf_y2d + SY) : '0;

`ifdef SEQ_WRITEBACK_EN
    wb_en_d   = (state_d == WRITE);
    wb_x_d    = (state_d == WRITE) ? bus.xf_x3d : '0;
    wb_y_d    = (state_d == WRITE) ? bus.xf_y3d : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      xf_req_q  <= 1'b0;
      xf_idx_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
`ifdef SEQ_WRITEBACK_EN
      wb_en_q   <= 1'b0;
      wb_x_q    <= '0;
      wb_y_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      xf_req_q  <= xf_req_d;
      xf_idx_q  <= xf_idx_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
`ifdef SEQ_WRITEBACK_EN
      wb_en_q   <= wb_en_d;
      wb_x_q    <= wb_x_d;
      wb_y_q    <= wb_y_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;
  assign bus.xf_req  = xf_req_q;
  assign bus.xf_idx  = xf_idx_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_idx  = wr_idx_q;
  assign bus.wr_x    = wr_x_q;
  assign bus.wr_y    = wr_y_q;

`ifdef SEQ_WRITEBACK_EN
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_x    = wb_x_q;
  assign bus.wb_y    = wb_y_q;
`else
  // No 3D capture: the rotated coordinates are not needed in this build.
  logic unused_xf_3d;
  assign unused_xf_3d = ^{bus.xf_x3d, bus.xf_y3d};
  assign bus.wb_en   = 1'b0;
  assign bus.wb_x    = '0;
  assign bus.wb_y    = '0;
`endif

endmodule

// File: tb/tb_pyramid_seq.sv
// -----------------------------------------------------------------------------
// tb_pyramid_seq
//   Directed frames against pyramid_seq (NUM_V=5, default offsets). Expected
//   store writes are queued when a frame is launched; a monitor pops and
//   compares each wr_en cycle. A responder models the transform unit with a
//   per-vertex ack delay.
// -----------------------------------------------------------------------------
module tb_pyramid_seq;
  import pyramid_pkg::*;

  localparam int NV = 5;
`ifdef SEQ_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pyramid_seq_if #(.NUM_V(NV)) bus ();

  pyramid_seq #(.NUM_V(NV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int x;
    int y;
    int wx;
    int wy;
  } exp_t;

  exp_t sb_q[$];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int req_cnt[NV];
  bit spurious = 1'b0;

  // Current frame, seen by the responder.
  int cur_x2d[NV], cur_y2d[NV], cur_x3d[NV], cur_y3d[NV], cur_dly[NV];

  // Frame A: immediate acks, includes the -50/25 and the +800 wrap vertices.
  int a_x2d[NV] = '{0, -50, 800, 100, -320};
  int a_y2d[NV] = '{0, 25, 0, -100, -340};
  int a_ex[NV]  = '{320, 270, 96, 420, 0};
  int a_ey[NV]  = '{340, 365, 340, 240, 0};
  int a_x3d[NV] = '{3, 10, 17, 24, 31};
  int a_y3d[NV] = '{1000, 999, 998, 997, 996};
  int a_dly[NV] = '{0, 0, 0, 0, 0};
  // Frame B: ack on vertex 2 delayed 3 cycles, Y wrap on vertex 1.
  int b_x2d[NV] = '{1, 511, -1, 200, -200};
  int b_y2d[NV] = '{2, -512, -1, 300, -300};
  int b_ex[NV]  = '{321, 831, 319, 520, 120};
  int b_ey[NV]  = '{342, 852, 339, 640, 40};
  int b_x3d[NV] = '{500, 400, 300, 200, 100};
  int b_y3d[NV] = '{5, 6, 7, 8, 9};
  int b_dly[NV] = '{0, 0, 3, 0, 0};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transform unit model: answers xf_req after cur_dly[idx] cycles; outside
  // REQ it may raise a spurious ack with junk data, which must be ignored.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.xf_ack = 1'b0;
    bus.xf_x2d = '0;
    bus.xf_y2d = '0;
    bus.xf_x3d = '0;
    bus.xf_y3d = '0;
    forever begin
      @(negedge clk);
      if (bus.xf_req) begin
        int i;
        i = int'(bus.xf_idx);
        if (wait_cnt >= cur_dly[i]) begin
          bus.xf_ack = 1'b1;
          bus.xf_x2d = 10'(cur_x2d[i]);
          bus.xf_y2d = 10'(cur_y2d[i]);
          bus.xf_x3d = 10'(cur_x3d[i]);
          bus.xf_y3d = 10'(cur_y3d[i]);
        end else begin
          bus.xf_ack = 1'b0;
          bus.xf_x2d = 10'h155;
          bus.xf_y2d = 10'h0AA;
          wait_cnt++;
        end
      end else begin
        wait_cnt   = 0;
        bus.xf_ack = spurious;
        bus.xf_x2d = 10'h1F0;
        bus.xf_y2d = 10'h10F;
        bus.xf_x3d = 10'h3C3;
        bus.xf_y3d = 10'h2A5;
      end
    end
  end

  // Monitor: pops the scoreboard on every store write.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.xf_req) req_cnt[bus.xf_idx]++;
      if (bus.done) done_cnt++;
      if (bus.wr_en || bus.wb_en)
        check("wb_en_vs_wr_en", int'(bus.wb_en), WB ? int'(bus.wr_en) : 0);
      if (bus.wr_en) begin
        wr_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_wr_en", int'(bus.wr_idx) + 100, -1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("wr_idx", int'(bus.wr_idx), e.idx);
          check("wr_x", int'(bus.wr_x), e.x);
          check("wr_y", int'(bus.wr_y), e.y);
          check("wb_x", int'(bus.wb_x), e.wx);
          check("wb_y", int'(bus.wb_y), e.wy);
        end
      end
    end
  end

  task automatic load_frame(input int f);
    for (int i = 0; i < NV; i++) begin
      exp_t e;
      cur_x2d[i] = (f == 0) ? a_x2d[i] : b_x2d[i];
      cur_y2d[i] = (f == 0) ? a_y2d[i] : b_y2d[i];
      cur_x3d[i] = (f == 0) ? a_x3d[i] : b_x3d[i];
      cur_y3d[i] = (f == 0) ? a_y3d[i] : b_y3d[i];
      cur_dly[i] = (f == 0) ? a_dly[i] : b_dly[i];
      e.idx = i;
      e.x   = (f == 0) ? a_ex[i] : b_ex[i];
      e.y   = (f == 0) ? a_ey[i] : b_ey[i];
      e.wx  = WB ? cur_x3d[i] : 0;
      e.wy  = WB ? cur_y3d[i] : 0;
      sb_q.push_back(e);
      req_cnt[i] = 0;
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start_t = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    bus.start_t = 1'b0;
  endtask

  // Waits for done (bounded); optionally re-pulses start_t while vertex
  // ovr_at is being requested.
  task automatic wait_done(input int ovr_at, output int lat);
    bit pulsed;
    pulsed = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      if (bus.done) begin
        lat = cyc - start_cyc;
        break;
      end
      if (ovr_at >= 0 && !pulsed && bus.xf_req && int'(bus.xf_idx) == ovr_at) begin
        bus.start_t = 1'b1;
        pulsed = 1'b1;
      end else begin
        bus.start_t = 1'b0;
      end
      @(negedge clk);
    end
    bus.start_t = 1'b0;
    check("done_seen", int'(lat >= 0), 1);
  endtask

  function automatic int any_out();
    return int'(|{bus.busy, bus.done, bus.overrun, bus.xf_req, bus.xf_idx,
                  bus.wr_en, bus.wr_idx, bus.wr_x, bus.wr_y,
                  bus.wb_en, bus.wb_x, bus.wb_y});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, w0;
    bus.start_t = 1'b0;
    for (int i = 0; i < NV; i++) begin
      req_cnt[i] = 0;
      cur_dly[i] = 0;
      cur_x2d[i] = 0;
      cur_y2d[i] = 0;
      cur_x3d[i] = 0;
      cur_y3d[i] = 0;
    end

    // Power-on reset
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", any_out(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame A: immediate acks, 11-cycle latency
    load_frame(0);
    start_pulse();
    wait_done(-1, lat);
    check("latency_a", lat, 11);
    check("req_cycles_a_v2", req_cnt[2], 1);
    repeat (3) @(negedge clk);
    check("queue_empty_a", sb_q.size(), 0);
    check("overrun_idle", int'(bus.overrun), 0);
    check("busy_after_a", int'(bus.busy), 0);

    // Frame B: vertex 2 ack delayed 3 cycles, spurious acks outside REQ
    spurious = 1'b1;
    load_frame(1);
    start_pulse();
    wait_done(-1, lat);
    check("latency_b", lat, 14);
    check("req_cycles_b_v2", req_cnt[2], 4);
    check("req_cycles_b_v1", req_cnt[1], 1);
    spurious = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_empty_b", sb_q.size(), 0);

    // Frame C: start_t during vertex 1 -> overrun, single done
    load_frame(0);
    d0 = done_cnt;
    start_pulse();
    wait_done(1, lat);
    check("latency_c", lat, 11);
    repeat (4) @(negedge clk);
    check("overrun_set", int'(bus.overrun), 1);
    check("single_done_c", done_cnt - d0, 1);
    check("busy_after_c", int'(bus.busy), 0);
    check("queue_empty_c", sb_q.size(), 0);

    // Frame D: reset while vertex 3 is requested
    load_frame(1);
    start_pulse();
    for (int k = 0; k < 100; k++) begin
      if (bus.xf_req && int'(bus.xf_idx) == 3) break;
      @(negedge clk);
    end
    check("reached_v3", int'(bus.xf_req && int'(bus.xf_idx) == 3), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", any_out(), 0);
    repeat (3) @(negedge clk);
    check("held_reset_outputs", any_out(), 0);
    check("abandoned_writes", sb_q.size(), 2);
    sb_q.delete();
    d0 = done_cnt;
    w0 = wr_cnt;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    check("no_wr_after_reset", wr_cnt - w0, 0);

    // Frame E: fresh frame after reset restarts at vertex 0
    load_frame(0);
    start_pulse();
    check("first_req_idx", int'(bus.xf_idx), 0);
    wait_done(-1, lat);
    check("latency_e", lat, 11);
    repeat (3) @(negedge clk);
    check("queue_empty_e", sb_q.size(), 0);
    check("overrun_cleared", int'(bus.overrun), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
